// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch sequencer with Start/Done harness handshake,
// absolute jumps, relative branches, halt/overrun detection and a saturating retire counter.
module fetch_unit #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Halt,
  input  logic             Jump,
  input  logic             BranchEn,
  input  logic             Taken,
  input  logic [PC_W-1:0]  Target,
  input  logic [OFF_W-1:0] Offset,
  input  logic             Stall,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Done,
  output logic             Overrun,
  output logic             Running,
  output logic [CNT_W-1:0] InstrCount
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, off_ext;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic done_q, done_d, ovr_q, ovr_d;
  assign off_ext = PC_W'($signed(Offset));
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE:  state_d = Start ? ARMED : IDLE;
      ARMED: state_d = Start ? ARMED : RUN;
      RUN: begin
        if (Start) state_d = ARMED;
        else if (!Stall) begin
          cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
          if (Halt) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else if (Jump) pc_d = Target;
          else if (BranchEn && Taken) pc_d = pc_q + off_ext;
          else if (&pc_q) begin
            // Stepping off the last ROM word: stop rather than wrap to 0.
            state_d = FIN;
            done_d  = 1'b1;
            ovr_d   = 1'b1;
          end else pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = Start ? ARMED : FIN;
    endcase
    // Entering or sitting in ARMED clears everything so the next launch starts at 0.
    if (state_d == ARMED) begin
      pc_d   = '0;
      cnt_d  = '0;
      done_d = 1'b0;
      ovr_d  = 1'b0;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end
  assign ProgCtr    = pc_q;
  assign InstrCount = cnt_q;
  assign Done       = done_q;
  assign Overrun    = ovr_q;
  assign Running    = (state_q == RUN);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table for launch/jump/branch/stall plus hand sequences
// for async reset, halt, overrun and abort.
module tb_fetch_unit;
  logic        Clk = 1'b0;
  logic        Reset_n, Start, Halt, Jump, BranchEn, Taken, Stall;
  logic [9:0]  Target;
  logic [7:0]  Offset;
  logic [9:0]  ProgCtr;
  logic        Done, Overrun, Running;
  logic [15:0] InstrCount;
  int checks = 0;
  int failures = 0;

  fetch_unit #(.PC_W(10), .OFF_W(8), .CNT_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt(Halt), .Jump(Jump),
    .BranchEn(BranchEn), .Taken(Taken), .Target(Target), .Offset(Offset),
    .Stall(Stall), .ProgCtr(ProgCtr), .Done(Done), .Overrun(Overrun),
    .Running(Running), .InstrCount(InstrCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic s, h, j, b, t, st;
    logic [9:0] tg;
    logic [7:0] of;
    logic [9:0] pc;
    logic d, o, r;
    logic [15:0] c;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t v(logic s, h, j, b, t, st, logic [9:0] tg, logic [7:0] of,
                             logic [9:0] pc, logic d, o, r, logic [15:0] c);
    vec_t x;
    x.s = s; x.h = h; x.j = j; x.b = b; x.t = t; x.st = st; x.tg = tg; x.of = of;
    x.pc = pc; x.d = d; x.o = o; x.r = r; x.c = c;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [9:0] pc, logic d, o, r, logic [15:0] c);
    chk({tag, ".pc"}, 32'(ProgCtr), 32'(pc));
    chk({tag, ".done"}, 32'(Done), 32'(d));
    chk({tag, ".ovr"}, 32'(Overrun), 32'(o));
    chk({tag, ".run"}, 32'(Running), 32'(r));
    chk({tag, ".cnt"}, 32'(InstrCount), 32'(c));
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_in();
    Start = 0; Halt = 0; Jump = 0; BranchEn = 0; Taken = 0; Stall = 0;
    Target = '0; Offset = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_n = 0;
    idle_in();
    tick();
    tick();
    chk_all("reset", 10'h000, 0, 0, 0, 16'd0);
    Reset_n = 1;
    tick();
    chk_all("idle", 10'h000, 0, 0, 0, 16'd0);

    //         s  h  j  b  t  st  tg      of     pc      d  o  r  cnt
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 10'h000, 8'h00, 10'h000, 0, 0, 0, 16'd0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 10'h000, 8'h00, 10'h000, 0, 0, 0, 16'd0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 10'h000, 8'h00, 10'h000, 0, 0, 0, 16'd0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 10'h000, 8'h00, 10'h000, 0, 0, 1, 16'd0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 10'h000, 8'h00, 10'h001, 0, 0, 1, 16'd1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 10'h000, 8'h00, 10'h002, 0, 0, 1, 16'd2));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 10'h000, 8'h00, 10'h003, 0, 0, 1, 16'd3));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 10'h000, 8'h00, 10'h004, 0, 0, 1, 16'd4));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 10'h000, 8'h00, 10'h005, 0, 0, 1, 16'd5));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 10'h120, 8'h00, 10'h120, 0, 0, 1, 16'd6));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 10'h000, 8'hFC, 10'h11C, 0, 0, 1, 16'd7));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 10'h120, 8'h00, 10'h120, 0, 0, 1, 16'd8));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 10'h000, 8'hFC, 10'h121, 0, 0, 1, 16'd9));
    vecs.push_back(v(0, 0, 1, 1, 1, 0, 10'h040, 8'h10, 10'h040, 0, 0, 1, 16'd10));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 10'h000, 8'h05, 10'h045, 0, 0, 1, 16'd11));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 10'h002, 8'h00, 10'h002, 0, 0, 1, 16'd12));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 10'h000, 8'hF0, 10'h3F2, 0, 0, 1, 16'd13));
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 10'h100, 8'h00, 10'h3F2, 0, 0, 1, 16'd13));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 10'h000, 8'h00, 10'h3F3, 0, 0, 1, 16'd14));
    for (int i = 0; i < vecs.size(); i++) begin
      Start = vecs[i].s; Halt = vecs[i].h; Jump = vecs[i].j; BranchEn = vecs[i].b;
      Taken = vecs[i].t; Stall = vecs[i].st; Target = vecs[i].tg; Offset = vecs[i].of;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].d, vecs[i].o, vecs[i].r, vecs[i].c);
    end

    // Asynchronous reset mid-run, observed before any clock edge.
    idle_in();
    #2 Reset_n = 0;
    #1;
    chk_all("async_rst", 10'h000, 0, 0, 0, 16'd0);
    tick();
    Reset_n = 1;

    // Launch, 7 sequential instructions, then halt.
    Start = 1;
    repeat (3) tick();
    chk_all("armed", 10'h000, 0, 0, 0, 16'd0);
    Start = 0;
    tick();
    chk_all("launch", 10'h000, 0, 0, 1, 16'd0);
    repeat (7) tick();
    chk_all("seq7", 10'h007, 0, 0, 1, 16'd7);
    Halt = 1;
    tick();
    Halt = 0;
    chk_all("halt", 10'h007, 1, 0, 0, 16'd8);
    Jump = 1; Target = 10'h155; Stall = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_all($sformatf("fin%0d", i), 10'h007, 1, 0, 0, 16'd8);
    end
    idle_in();
    Start = 1;
    tick();
    chk_all("fin_start", 10'h000, 0, 0, 0, 16'd0);

    // Stall at PC=9 with a jump pending.
    Start = 0;
    tick();
    repeat (9) tick();
    chk_all("pre_stall", 10'h009, 0, 0, 1, 16'd9);
    Stall = 1; Jump = 1; Target = 10'h200;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all($sformatf("stall%0d", i), 10'h009, 0, 0, 1, 16'd9);
    end
    idle_in();
    tick();
    chk_all("post_stall", 10'h00A, 0, 0, 1, 16'd10);

    // Overrun from the last ROM address.
    Jump = 1; Target = 10'h3FF;
    tick();
    idle_in();
    chk_all("to_last", 10'h3FF, 0, 0, 1, 16'd11);
    tick();
    chk_all("overrun", 10'h3FF, 1, 1, 0, 16'd12);
    tick();
    chk_all("overrun_hold", 10'h3FF, 1, 1, 0, 16'd12);
    Start = 1;
    tick();
    chk_all("ovr_clear", 10'h000, 0, 0, 0, 16'd0);

    // Abort from RUN.
    Start = 0;
    tick();
    Jump = 1; Target = 10'h033;
    tick();
    chk_all("at33", 10'h033, 0, 0, 1, 16'd1);
    Start = 1; Target = 10'h080;
    tick();
    chk_all("abort", 10'h000, 0, 0, 0, 16'd0);
    idle_in();
    tick();
    chk_all("relaunch", 10'h000, 0, 0, 1, 16'd0);
    tick();
    chk_all("relaunch1", 10'h001, 0, 0, 1, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
